// File: rtl/ciq_pkg.sv
// ============================================================================
// Module   : ciq_pkg
// Brief    : Shared widths and entry record for the centralized issue queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ciq_pkg;

    localparam int c_OPCODE_W = 7;
    localparam int c_PRF_W    = 6;

    typedef struct packed {
        logic                  valid;
        logic [c_OPCODE_W-1:0] op;
        logic [c_PRF_W-1:0]    prs1;
        logic                  prs1_v;
        logic                  prs1_rdy;
        logic [c_PRF_W-1:0]    prs2;
        logic                  prs2_v;
        logic                  prs2_rdy;
        logic [c_PRF_W-1:0]    prd;
        logic                  prd_v;
    } ciq_entry_t;

    // An unused source never blocks issue.
    function automatic logic f_src_ready(input logic v, input logic rdy);
        return !v || rdy;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ciq_oldest_select.sv
// ============================================================================
// Module   : ciq_oldest_select
// Brief    : Age matrix plus iterative oldest-first grant of up to ISSUE_NUM entries.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ciq_oldest_select #(
    parameter int CIQ_DEPTH = 16,
    parameter int ISSUE_NUM = 2,
    parameter int SLOT_W    = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush_i,
    input  logic [CIQ_DEPTH-1:0]                 valid_i,
    input  logic [CIQ_DEPTH-1:0]                 elig_i,
    input  logic [CIQ_DEPTH-1:0]                 alloc_i,
    input  logic [CIQ_DEPTH-1:0][SLOT_W-1:0]     alloc_rank_i,
    output logic [ISSUE_NUM-1:0][CIQ_DEPTH-1:0]  grant_o
);

    // old_q[i][j] = 1 : entry i is older than entry j
    logic [CIQ_DEPTH-1:0][CIQ_DEPTH-1:0] old_q;
    logic [CIQ_DEPTH-1:0][CIQ_DEPTH-1:0] old_d;
    logic [CIQ_DEPTH-1:0][CIQ_DEPTH-1:0] w_older;
    logic [CIQ_DEPTH-1:0]                w_remain;
    logic [CIQ_DEPTH-1:0]                w_granted;
    logic [CIQ_DEPTH-1:0]                w_keep;
    logic                                w_found;

    always_comb begin
        for (int i = 0; i < CIQ_DEPTH; i++) begin
            for (int j = 0; j < CIQ_DEPTH; j++) begin
                w_older[i][j] = old_q[j][i];
            end
        end
    end

    always_comb begin
        w_remain  = elig_i;
        w_granted = '0;
        w_found   = 1'b0;
        grant_o   = '0;
        for (int p = 0; p < ISSUE_NUM; p++) begin
            w_found = 1'b0;
            for (int i = 0; i < CIQ_DEPTH; i++) begin
                if (w_remain[i] && ((w_remain & w_older[i]) == '0) && !w_found) begin
                    grant_o[p][i] = 1'b1;
                    w_found       = 1'b1;
                end
            end
            w_remain  = w_remain & ~grant_o[p];
            w_granted = w_granted | grant_o[p];
        end
    end

    // A new entry is younger than every surviving entry and than lower dispatch slots.
    always_comb begin
        w_keep = valid_i & ~w_granted;
        for (int i = 0; i < CIQ_DEPTH; i++) begin
            for (int j = 0; j < CIQ_DEPTH; j++) begin
                if (alloc_i[j]) begin
                    old_d[i][j] = w_keep[i] || (alloc_i[i] && (alloc_rank_i[i] < alloc_rank_i[j]));
                end else if (alloc_i[i]) begin
                    old_d[i][j] = 1'b0;
                end else begin
                    old_d[i][j] = old_q[i][j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            old_q <= '0;
        end else begin
            old_q <= old_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ciq_age_issue.sv
// ============================================================================
// Module   : ciq_age_issue
// Brief    : Centralized issue queue with tag wakeup and age-ordered multi-issue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ciq_age_issue
    import ciq_pkg::*;
#(
    parameter int INSTR_NUM = 4,
    parameter int ISSUE_NUM = 2,
    parameter int CIQ_DEPTH = 16,
    parameter int WB_NUM    = 4,
    parameter int OPCODE    = c_OPCODE_W,
    parameter int PRF_WIDTH = c_PRF_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush_i,
    input  logic [INSTR_NUM-1:0]                  disp_valid_i,
    output logic                                  disp_ready_o,
    input  logic [INSTR_NUM-1:0][OPCODE-1:0]      disp_op_i,
    input  logic [INSTR_NUM-1:0][PRF_WIDTH-1:0]   disp_prs1_i,
    input  logic [INSTR_NUM-1:0][PRF_WIDTH-1:0]   disp_prs2_i,
    input  logic [INSTR_NUM-1:0]                  disp_prs1_v_i,
    input  logic [INSTR_NUM-1:0]                  disp_prs2_v_i,
    input  logic [INSTR_NUM-1:0]                  disp_prs1_rdy_i,
    input  logic [INSTR_NUM-1:0]                  disp_prs2_rdy_i,
    input  logic [INSTR_NUM-1:0][PRF_WIDTH-1:0]   disp_prd_i,
    input  logic [INSTR_NUM-1:0]                  disp_prd_v_i,
    input  logic [WB_NUM-1:0]                     wb_valid_i,
    input  logic [WB_NUM-1:0][PRF_WIDTH-1:0]      wb_prd_i,
    output logic [ISSUE_NUM-1:0]                  iss_valid_o,
    output logic [ISSUE_NUM-1:0][OPCODE-1:0]      iss_op_o,
    output logic [ISSUE_NUM-1:0][PRF_WIDTH-1:0]   iss_prs1_o,
    output logic [ISSUE_NUM-1:0][PRF_WIDTH-1:0]   iss_prs2_o,
    output logic [ISSUE_NUM-1:0][PRF_WIDTH-1:0]   iss_prd_o,
    output logic [ISSUE_NUM-1:0]                  iss_prd_v_o,
    output logic [$clog2(CIQ_DEPTH+1)-1:0]        free_cnt_o
);

    localparam int c_IDX_W  = $clog2(CIQ_DEPTH);
    localparam int c_SLOT_W = (INSTR_NUM > 1) ? $clog2(INSTR_NUM) : 1;
    localparam int c_CNT_W  = $clog2(CIQ_DEPTH+1);

    ciq_entry_t [CIQ_DEPTH-1:0]              entry_q;
    ciq_entry_t [CIQ_DEPTH-1:0]              entry_d;
    logic [c_CNT_W-1:0]                      free_cnt_q;
    logic [c_CNT_W-1:0]                      free_cnt_d;
    logic [ISSUE_NUM-1:0]                    iss_valid_q;
    logic [ISSUE_NUM-1:0][OPCODE-1:0]        iss_op_q;
    logic [ISSUE_NUM-1:0][PRF_WIDTH-1:0]     iss_prs1_q;
    logic [ISSUE_NUM-1:0][PRF_WIDTH-1:0]     iss_prs2_q;
    logic [ISSUE_NUM-1:0][PRF_WIDTH-1:0]     iss_prd_q;
    logic [ISSUE_NUM-1:0]                    iss_prd_v_q;

    logic [CIQ_DEPTH-1:0]                    w_valid;
    logic [CIQ_DEPTH-1:0]                    w_elig;
    logic [CIQ_DEPTH-1:0]                    w_avail;
    logic [CIQ_DEPTH-1:0]                    w_alloc;
    logic [CIQ_DEPTH-1:0]                    w_issued;
    logic [CIQ_DEPTH-1:0][c_SLOT_W-1:0]      w_alloc_rank;
    logic [INSTR_NUM-1:0][c_IDX_W-1:0]       w_slot_idx;
    logic [INSTR_NUM-1:0]                    w_slot_hit;
    logic                                    w_accept;
    ciq_entry_t [INSTR_NUM-1:0]              w_new;
    logic [ISSUE_NUM-1:0][CIQ_DEPTH-1:0]     w_grant;
    ciq_entry_t [ISSUE_NUM-1:0]              w_iss_entry;
    logic [ISSUE_NUM-1:0]                    w_iss_valid;

    function automatic logic f_wake(
        input logic [PRF_WIDTH-1:0]             tag,
        input logic [WB_NUM-1:0]                wbv,
        input logic [WB_NUM-1:0][PRF_WIDTH-1:0] wbt
    );
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WB_NUM; w++) begin
            if (wbv[w] && (wbt[w] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign disp_ready_o = (free_cnt_q >= c_CNT_W'(INSTR_NUM)) && !flush_i;
    assign w_accept     = disp_ready_o;

    always_comb begin
        for (int i = 0; i < CIQ_DEPTH; i++) begin
            w_valid[i] = entry_q[i].valid;
            w_elig[i]  = entry_q[i].valid && !flush_i
                         && f_src_ready(entry_q[i].prs1_v, entry_q[i].prs1_rdy)
                         && f_src_ready(entry_q[i].prs2_v, entry_q[i].prs2_rdy);
        end
    end

    // Each valid slot claims the lowest free entry left over by lower slots.
    always_comb begin
        w_avail      = ~w_valid;
        w_alloc      = '0;
        w_alloc_rank = '0;
        w_slot_idx   = '0;
        w_slot_hit   = '0;
        for (int s = 0; s < INSTR_NUM; s++) begin
            for (int i = 0; i < CIQ_DEPTH; i++) begin
                if (w_avail[i] && !w_slot_hit[s]) begin
                    w_slot_idx[s] = c_IDX_W'(i);
                    w_slot_hit[s] = 1'b1;
                end
            end
            if (disp_valid_i[s] && w_slot_hit[s]) begin
                w_avail[w_slot_idx[s]] = 1'b0;
                if (w_accept) begin
                    w_alloc[w_slot_idx[s]]      = 1'b1;
                    w_alloc_rank[w_slot_idx[s]] = c_SLOT_W'(s);
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < INSTR_NUM; s++) begin
            w_new[s].valid    = 1'b1;
            w_new[s].op       = disp_op_i[s];
            w_new[s].prs1     = disp_prs1_i[s];
            w_new[s].prs1_v   = disp_prs1_v_i[s];
            w_new[s].prs1_rdy = disp_prs1_rdy_i[s] || f_wake(disp_prs1_i[s], wb_valid_i, wb_prd_i);
            w_new[s].prs2     = disp_prs2_i[s];
            w_new[s].prs2_v   = disp_prs2_v_i[s];
            w_new[s].prs2_rdy = disp_prs2_rdy_i[s] || f_wake(disp_prs2_i[s], wb_valid_i, wb_prd_i);
            w_new[s].prd      = disp_prd_i[s];
            w_new[s].prd_v    = disp_prd_v_i[s];
        end
    end

    ciq_oldest_select #(
        .CIQ_DEPTH (CIQ_DEPTH),
        .ISSUE_NUM (ISSUE_NUM),
        .SLOT_W    (c_SLOT_W)
    ) u_select (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .valid_i      (w_valid),
        .elig_i       (w_elig),
        .alloc_i      (w_alloc),
        .alloc_rank_i (w_alloc_rank),
        .grant_o      (w_grant)
    );

    always_comb begin
        w_issued = '0;
        for (int p = 0; p < ISSUE_NUM; p++) begin
            w_issued       = w_issued | w_grant[p];
            w_iss_valid[p] = |w_grant[p];
            w_iss_entry[p] = '0;
            for (int i = 0; i < CIQ_DEPTH; i++) begin
                if (w_grant[p][i]) begin
                    w_iss_entry[p] = entry_q[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CIQ_DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (flush_i) begin
                entry_d[i] = '0;
            end else if (w_alloc[i]) begin
                entry_d[i] = w_new[w_alloc_rank[i]];
            end else if (w_issued[i]) begin
                entry_d[i].valid = 1'b0;
            end else begin
                if (f_wake(entry_q[i].prs1, wb_valid_i, wb_prd_i)) begin
                    entry_d[i].prs1_rdy = 1'b1;
                end
                if (f_wake(entry_q[i].prs2, wb_valid_i, wb_prd_i)) begin
                    entry_d[i].prs2_rdy = 1'b1;
                end
            end
        end
    end

    always_comb begin
        free_cnt_d = c_CNT_W'(CIQ_DEPTH);
        for (int i = 0; i < CIQ_DEPTH; i++) begin
            if (entry_d[i].valid) begin
                free_cnt_d = free_cnt_d - c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q     <= '0;
            free_cnt_q  <= c_CNT_W'(CIQ_DEPTH);
            iss_valid_q <= '0;
            iss_op_q    <= '0;
            iss_prs1_q  <= '0;
            iss_prs2_q  <= '0;
            iss_prd_q   <= '0;
            iss_prd_v_q <= '0;
        end else begin
            entry_q     <= entry_d;
            free_cnt_q  <= free_cnt_d;
            iss_valid_q <= w_iss_valid;
            for (int p = 0; p < ISSUE_NUM; p++) begin
                if (w_iss_valid[p]) begin
                    iss_op_q[p]    <= w_iss_entry[p].op;
                    iss_prs1_q[p]  <= w_iss_entry[p].prs1;
                    iss_prs2_q[p]  <= w_iss_entry[p].prs2;
                    iss_prd_q[p]   <= w_iss_entry[p].prd;
                    iss_prd_v_q[p] <= w_iss_entry[p].prd_v;
                end
            end
        end
    end

    assign iss_valid_o = iss_valid_q;
    assign iss_op_o    = iss_op_q;
    assign iss_prs1_o  = iss_prs1_q;
    assign iss_prs2_o  = iss_prs2_q;
    assign iss_prd_o   = iss_prd_q;
    assign iss_prd_v_o = iss_prd_v_q;
    assign free_cnt_o  = free_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ciq_age_issue.sv
// ============================================================================
// Module   : tb_ciq_age_issue
// Brief    : Directed table-driven and sequence checks for ciq_age_issue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ciq_age_issue;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush_i;
    logic [3:0]       disp_valid_i;
    logic             disp_ready_o;
    logic [3:0][6:0]  disp_op_i;
    logic [3:0][5:0]  disp_prs1_i;
    logic [3:0][5:0]  disp_prs2_i;
    logic [3:0]       disp_prs1_v_i;
    logic [3:0]       disp_prs2_v_i;
    logic [3:0]       disp_prs1_rdy_i;
    logic [3:0]       disp_prs2_rdy_i;
    logic [3:0][5:0]  disp_prd_i;
    logic [3:0]       disp_prd_v_i;
    logic [3:0]       wb_valid_i;
    logic [3:0][5:0]  wb_prd_i;
    logic [1:0]       iss_valid_o;
    logic [1:0][6:0]  iss_op_o;
    logic [1:0][5:0]  iss_prs1_o;
    logic [1:0][5:0]  iss_prs2_o;
    logic [1:0][5:0]  iss_prd_o;
    logic [1:0]       iss_prd_v_o;
    logic [4:0]       free_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    ciq_age_issue dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .disp_valid_i    (disp_valid_i),
        .disp_ready_o    (disp_ready_o),
        .disp_op_i       (disp_op_i),
        .disp_prs1_i     (disp_prs1_i),
        .disp_prs2_i     (disp_prs2_i),
        .disp_prs1_v_i   (disp_prs1_v_i),
        .disp_prs2_v_i   (disp_prs2_v_i),
        .disp_prs1_rdy_i (disp_prs1_rdy_i),
        .disp_prs2_rdy_i (disp_prs2_rdy_i),
        .disp_prd_i      (disp_prd_i),
        .disp_prd_v_i    (disp_prd_v_i),
        .wb_valid_i      (wb_valid_i),
        .wb_prd_i        (wb_prd_i),
        .iss_valid_o     (iss_valid_o),
        .iss_op_o        (iss_op_o),
        .iss_prs1_o      (iss_prs1_o),
        .iss_prs2_o      (iss_prs2_o),
        .iss_prd_o       (iss_prd_o),
        .iss_prd_v_o     (iss_prd_v_o),
        .free_cnt_o      (free_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       flush;
        logic [3:0] dv;
        logic [3:0] rdy;
        logic [6:0] op0;
        logic [5:0] tag0;
        logic       wbv;
        logic [5:0] wbt;
        logic       exp_rdy;
        logic [1:0] exp_iv;
        logic [6:0] exp_op0;
        logic [6:0] exp_op1;
        logic [4:0] exp_free;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(
        input logic fl, input logic [3:0] dv, input logic [3:0] rdy, input logic [6:0] op0,
        input logic [5:0] tag0, input logic wbv, input logic [5:0] wbt, input logic erdy,
        input logic [1:0] eiv, input logic [6:0] eop0, input logic [6:0] eop1, input logic [4:0] efree
    );
        vec_t v;
        v.flush = fl;    v.dv = dv;       v.rdy = rdy;       v.op0 = op0;
        v.tag0 = tag0;   v.wbv = wbv;     v.wbt = wbt;       v.exp_rdy = erdy;
        v.exp_iv = eiv;  v.exp_op0 = eop0; v.exp_op1 = eop1; v.exp_free = efree;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush_i         = 1'b0;
        disp_valid_i    = '0;
        disp_op_i       = '0;
        disp_prs1_i     = '0;
        disp_prs2_i     = '0;
        disp_prs1_v_i   = '0;
        disp_prs2_v_i   = '0;
        disp_prs1_rdy_i = '0;
        disp_prs2_rdy_i = '0;
        disp_prd_i      = '0;
        disp_prd_v_i    = '0;
        wb_valid_i      = '0;
        wb_prd_i        = '0;
    endtask

    task automatic drive_slot(
        input int s, input logic [6:0] op,
        input logic [5:0] p1, input logic p1v, input logic p1r,
        input logic [5:0] p2, input logic p2v, input logic p2r,
        input logic [5:0] prd
    );
        disp_valid_i[s]    = 1'b1;
        disp_op_i[s]       = op;
        disp_prs1_i[s]     = p1;
        disp_prs1_v_i[s]   = p1v;
        disp_prs1_rdy_i[s] = p1r;
        disp_prs2_i[s]     = p2;
        disp_prs2_v_i[s]   = p2v;
        disp_prs2_rdy_i[s] = p2r;
        disp_prd_i[s]      = prd;
        disp_prd_v_i[s]    = 1'b1;
    endtask

    initial begin
        vecs[0]  = mk(0, 4'hF, 4'hF, 7'h10, 6'd0,  0, 6'd0,  1, 2'b00, 7'h00, 7'h00, 5'd12);
        vecs[1]  = mk(0, 4'h0, 4'h0, 7'h00, 6'd0,  0, 6'd0,  1, 2'b11, 7'h10, 7'h11, 5'd14);
        vecs[2]  = mk(0, 4'h0, 4'h0, 7'h00, 6'd0,  0, 6'd0,  1, 2'b11, 7'h12, 7'h13, 5'd16);
        vecs[3]  = mk(0, 4'h0, 4'h0, 7'h00, 6'd0,  0, 6'd0,  1, 2'b00, 7'h00, 7'h00, 5'd16);
        vecs[4]  = mk(0, 4'h1, 4'h0, 7'h20, 6'd5,  0, 6'd0,  1, 2'b00, 7'h00, 7'h00, 5'd15);
        vecs[5]  = mk(0, 4'h1, 4'h1, 7'h21, 6'd0,  0, 6'd0,  1, 2'b00, 7'h00, 7'h00, 5'd14);
        vecs[6]  = mk(0, 4'h0, 4'h0, 7'h00, 6'd0,  0, 6'd0,  1, 2'b01, 7'h21, 7'h00, 5'd15);
        vecs[7]  = mk(0, 4'h0, 4'h0, 7'h00, 6'd0,  1, 6'd5,  1, 2'b00, 7'h00, 7'h00, 5'd15);
        vecs[8]  = mk(0, 4'h0, 4'h0, 7'h00, 6'd0,  0, 6'd0,  1, 2'b01, 7'h20, 7'h00, 5'd16);
        vecs[9]  = mk(0, 4'hF, 4'h0, 7'h30, 6'd16, 0, 6'd0,  1, 2'b00, 7'h00, 7'h00, 5'd12);
        vecs[10] = mk(0, 4'hF, 4'h0, 7'h34, 6'd20, 0, 6'd0,  1, 2'b00, 7'h00, 7'h00, 5'd8);
        vecs[11] = mk(0, 4'hF, 4'h0, 7'h38, 6'd24, 0, 6'd0,  1, 2'b00, 7'h00, 7'h00, 5'd4);
        vecs[12] = mk(0, 4'h1, 4'h0, 7'h3C, 6'd28, 0, 6'd0,  1, 2'b00, 7'h00, 7'h00, 5'd3);
        vecs[13] = mk(0, 4'h1, 4'h1, 7'h40, 6'd0,  0, 6'd0,  0, 2'b00, 7'h00, 7'h00, 5'd3);
        vecs[14] = mk(0, 4'h1, 4'h1, 7'h41, 6'd0,  1, 6'd16, 0, 2'b00, 7'h00, 7'h00, 5'd3);
        vecs[15] = mk(0, 4'h1, 4'h1, 7'h41, 6'd0,  0, 6'd0,  0, 2'b01, 7'h30, 7'h00, 5'd4);
        vecs[16] = mk(0, 4'h1, 4'h1, 7'h41, 6'd0,  0, 6'd0,  1, 2'b00, 7'h00, 7'h00, 5'd3);
        vecs[17] = mk(0, 4'h0, 4'h0, 7'h00, 6'd0,  0, 6'd0,  0, 2'b01, 7'h41, 7'h00, 5'd4);
        vecs[18] = mk(1, 4'h0, 4'h0, 7'h00, 6'd0,  0, 6'd0,  0, 2'b00, 7'h00, 7'h00, 5'd16);
        vecs[19] = mk(0, 4'h0, 4'h0, 7'h00, 6'd0,  0, 6'd0,  1, 2'b00, 7'h00, 7'h00, 5'd16);

        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_iss_valid", int'(iss_valid_o), 0);
        chk("reset_free_cnt", int'(free_cnt_o), 16);
        chk("reset_disp_ready", int'(disp_ready_o), 1);
        chk("reset_iss_op", int'(iss_op_o), 0);
        chk("reset_iss_prd", int'(iss_prd_o), 0);

        // One table row per cycle: inputs, disp_ready before the edge, outputs after it.
        for (int n = 0; n < 20; n++) begin
            clear_inputs();
            flush_i = vecs[n].flush;
            for (int s = 0; s < 4; s++) begin
                if (vecs[n].dv[s]) begin
                    drive_slot(s, vecs[n].op0 + 7'(s), vecs[n].tag0 + 6'(s), 1'b1, vecs[n].rdy[s],
                               6'd0, 1'b0, 1'b0, vecs[n].op0[5:0] + 6'(s));
                end
            end
            wb_valid_i[0] = vecs[n].wbv;
            wb_prd_i[0]   = vecs[n].wbt;
            #1;
            chk($sformatf("row%0d_disp_ready", n), int'(disp_ready_o), int'(vecs[n].exp_rdy));
            tick();
            chk($sformatf("row%0d_iss_valid", n), int'(iss_valid_o), int'(vecs[n].exp_iv));
            chk($sformatf("row%0d_free_cnt", n), int'(free_cnt_o), int'(vecs[n].exp_free));
            if (vecs[n].exp_iv[0]) chk($sformatf("row%0d_op0", n), int'(iss_op_o[0]), int'(vecs[n].exp_op0));
            if (vecs[n].exp_iv[1]) chk($sformatf("row%0d_op1", n), int'(iss_op_o[1]), int'(vecs[n].exp_op1));
        end
        clear_inputs();

        // Same-cycle wakeup of a dispatching source (prs2 tag 9 on wb port 2).
        drive_slot(0, 7'h60, 6'd0, 1'b0, 1'b0, 6'd9,  1'b1, 1'b0, 6'h2A);
        drive_slot(1, 7'h61, 6'd0, 1'b0, 1'b0, 6'd10, 1'b1, 1'b0, 6'd11);
        wb_valid_i[2] = 1'b1;
        wb_prd_i[2]   = 6'd9;
        tick();
        clear_inputs();
        chk("sc_wake_iv_t1", int'(iss_valid_o), 0);
        chk("sc_wake_free_t1", int'(free_cnt_o), 14);
        tick();
        chk("sc_wake_iv_t2", int'(iss_valid_o), 1);
        chk("sc_wake_op", int'(iss_op_o[0]), 'h60);
        chk("sc_wake_prs2", int'(iss_prs2_o[0]), 9);
        chk("sc_wake_prd", int'(iss_prd_o[0]), 'h2A);
        chk("sc_wake_prd_v", int'(iss_prd_v_o[0]), 1);
        chk("sc_wake_free_t2", int'(free_cnt_o), 15);
        tick();
        chk("sc_wake_iv_t3", int'(iss_valid_o), 0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("sc_wake_flush_free", int'(free_cnt_o), 16);

        // Place entries so that ages 0,1,2 sit at indices 7,2,12.
        for (int g = 0; g < 4; g++) begin
            for (int s = 0; s < 4; s++) begin
                drive_slot(s, 7'(g * 4 + s), 6'(32 + g * 4 + s), 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 6'(g * 4 + s));
            end
            tick();
            clear_inputs();
        end
        chk("age_full_free", int'(free_cnt_o), 0);
        wb_valid_i = 4'hF;
        wb_prd_i   = {6'd47, 6'd46, 6'd45, 6'd39};
        tick();
        clear_inputs();
        chk("age_wake_iv0", int'(iss_valid_o), 0);
        tick();
        chk("age_first_iv", int'(iss_valid_o), 3);
        chk("age_first_op0", int'(iss_op_o[0]), 7);
        chk("age_first_op1", int'(iss_op_o[1]), 13);
        tick();
        chk("age_second_op0", int'(iss_op_o[0]), 14);
        chk("age_second_op1", int'(iss_op_o[1]), 15);
        chk("age_second_free", int'(free_cnt_o), 4);
        drive_slot(0, 7'h57, 6'd50, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 6'd1);
        tick();
        clear_inputs();
        wb_valid_i[0] = 1'b1;
        wb_prd_i[0]   = 6'd34;
        tick();
        clear_inputs();
        tick();
        chk("age_free_idx2_op", int'(iss_op_o[0]), 2);
        drive_slot(0, 7'h52, 6'd50, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 6'd2);
        tick();
        clear_inputs();
        wb_valid_i[0] = 1'b1;
        wb_prd_i[0]   = 6'd44;
        tick();
        clear_inputs();
        tick();
        chk("age_free_idx12_op", int'(iss_op_o[0]), 12);
        drive_slot(0, 7'h5C, 6'd50, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 6'd3);
        tick();
        clear_inputs();
        wb_valid_i[0] = 1'b1;
        wb_prd_i[0]   = 6'd50;
        tick();
        clear_inputs();
        tick();
        chk("age_pick_iv", int'(iss_valid_o), 3);
        chk("age_pick_port0", int'(iss_op_o[0]), 'h57);
        chk("age_pick_port1", int'(iss_op_o[1]), 'h52);
        tick();
        chk("age_next_iv", int'(iss_valid_o), 1);
        chk("age_next_port0", int'(iss_op_o[0]), 'h5C);
        chk("age_remaining_free", int'(free_cnt_o), 6);

        // Flush with 10 valid entries and a pending dispatch.
        flush_i = 1'b1;
        for (int s = 0; s < 4; s++) begin
            drive_slot(s, 7'(8'h70 + s), 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'(s));
        end
        #1;
        chk("flush_disp_ready", int'(disp_ready_o), 0);
        tick();
        clear_inputs();
        chk("flush_free", int'(free_cnt_o), 16);
        chk("flush_iv", int'(iss_valid_o), 0);
        tick();
        chk("flush_dropped_iv", int'(iss_valid_o), 0);
        chk("flush_dropped_free", int'(free_cnt_o), 16);

        // Reset while issuing clears outputs.
        for (int s = 0; s < 4; s++) begin
            drive_slot(s, 7'(8'h78 + s), 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'(s + 1));
        end
        tick();
        clear_inputs();
        tick();
        chk("pre_rst_iv", int'(iss_valid_o), 3);
        chk("pre_rst_op1", int'(iss_op_o[1]), 'h79);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_iv", int'(iss_valid_o), 0);
        chk("rst_op", int'(iss_op_o), 0);
        chk("rst_free", int'(free_cnt_o), 16);
        tick();
        chk("rst_after_iv", int'(iss_valid_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
